// File: rtl/icache_responder_pkg.sv
// Shared widths, constants and FSM encodings for the instruction cache responder.
// Latency/backpressure: none; this package holds no logic.
package icache_responder_pkg;
  localparam int PcLength    = 31;
  localparam int InstrLength = 31;
  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;
  localparam logic [31:0] Zero = 32'd0;

  localparam int IcIndexBits = 4;
  localparam int IcTagBits   = 32 - IcIndexBits - 2;

  typedef enum logic [1:0] {
    IcIdle = 2'd0,
    IcFill = 2'd1,
    IcResp = 2'd2
  } ic_state_t;
endpackage

// File: rtl/icache_line_array.sv
// Direct-mapped line store: combinational read gives hit/data, single synchronous write port.
// Latency: read is combinational, write visible the cycle after wr_en; no backpressure.
module icache_line_array
  import icache_responder_pkg::*;
#(
  parameter int IndexBits = IcIndexBits,
  parameter int TagBits   = IcTagBits
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IndexBits-1:0] rd_index,
  input  logic [TagBits-1:0]   rd_tag,
  output logic                 rd_hit,
  output logic [InstrLength:0] rd_data,
  input  logic                 wr_en,
  input  logic [IndexBits-1:0] wr_index,
  input  logic [TagBits-1:0]   wr_tag,
  input  logic [InstrLength:0] wr_data
);
  localparam int Lines = 1 << IndexBits;

  logic [Lines-1:0]     valid_q;
  logic [TagBits-1:0]   tag_q  [Lines];
  logic [InstrLength:0] data_q [Lines];

  // Only the valid bits need reset; tag/data are meaningless until valid is set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= True;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_hit  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
  assign rd_data = data_q[rd_index];
endmodule

// File: rtl/icache_responder.sv
// Instruction cache front end: 1-cycle hit pulse, byte-serial refill from memory on a miss.
// Latency: hit 1 cycle, miss 4 byte-valid cycles + 1; new requests are ignored until the answer pulse has been seen.
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int IndexBits = IcIndexBits,
  parameter int TagBits   = 32 - IndexBits - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 is_exception_from_rob,
  input  logic                 is_empty_from_iq,
  input  logic [PcLength:0]    pc_from_iq,
  output logic                 is_hit_to_iq,
  output logic [InstrLength:0] instr_to_iq,
  output logic                 is_request_to_mc,
  output logic [PcLength:0]    addr_to_mc,
  input  logic                 is_valid_from_mc,
  input  logic [7:0]           byte_from_mc
);
  ic_state_t state_q, state_d;

  logic [1:0]           k_q;
  logic [PcLength:0]    pc_q;
  logic [23:0]          part_q;
  logic                 line_hit;
  logic [InstrLength:0] line_data;
  logic [InstrLength:0] fill_word;
  logic                 req_vld, take_hit, start_fill, take_byte, last_byte;

  // Gating on is_hit_to_iq drops the request the queue still holds during the answer cycle.
  assign req_vld   = !is_empty_from_iq && !is_exception_from_rob && !is_hit_to_iq;
  assign fill_word = {byte_from_mc, part_q};

  icache_line_array #(
    .IndexBits(IndexBits),
    .TagBits  (TagBits)
  ) u_lines (
    .clk     (clk),
    .rst     (rst),
    .rd_index(pc_from_iq[IndexBits+1:2]),
    .rd_tag  (pc_from_iq[31:IndexBits+2]),
    .rd_hit  (line_hit),
    .rd_data (line_data),
    .wr_en   (last_byte),
    .wr_index(pc_q[IndexBits+1:2]),
    .wr_tag  (pc_q[31:IndexBits+2]),
    .wr_data (fill_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IcIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    take_hit   = False;
    start_fill = False;
    take_byte  = False;
    last_byte  = False;
    if (is_exception_from_rob) begin
      state_d = IcIdle;
    end else begin
      case (state_q)
        IcIdle: begin
          if (req_vld) begin
            if (line_hit) begin
              take_hit = True;
            end else begin
              start_fill = True;
              state_d    = IcFill;
            end
          end
        end
        IcFill: begin
          if (is_valid_from_mc) begin
            take_byte = True;
            if (k_q == 2'd3) begin
              last_byte = True;
              state_d   = IcResp;
            end
          end
        end
        IcResp:  state_d = IcIdle;
        default: state_d = IcIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q              <= 2'd0;
      pc_q             <= Zero;
      part_q           <= '0;
      is_hit_to_iq     <= False;
      instr_to_iq      <= Zero;
      is_request_to_mc <= False;
      addr_to_mc       <= Zero;
    end else begin
      is_hit_to_iq <= take_hit || last_byte;
      if (take_hit) begin
        instr_to_iq <= line_data;
      end else if (last_byte) begin
        instr_to_iq <= fill_word;
      end

      if (is_exception_from_rob) begin
        is_request_to_mc <= False;
        k_q              <= 2'd0;
      end else if (start_fill) begin
        pc_q             <= pc_from_iq;
        addr_to_mc       <= pc_from_iq;
        is_request_to_mc <= True;
        k_q              <= 2'd0;
      end else if (take_byte) begin
        // The top byte is never stored: it goes straight into the line write.
        if (!last_byte) begin
          part_q[{k_q, 3'b000} +: 8] <= byte_from_mc;
        end else begin
          is_request_to_mc <= False;
        end
        k_q        <= k_q + 2'd1;
        addr_to_mc <= pc_q + {30'd0, k_q} + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: vector table of fetches plus flush/reset corner sequences.
module tb_icache_responder;
  logic        clk;
  logic        rst;
  logic        is_exception_from_rob;
  logic        is_empty_from_iq;
  logic [31:0] pc_from_iq;
  logic        is_hit_to_iq;
  logic [31:0] instr_to_iq;
  logic        is_request_to_mc;
  logic [31:0] addr_to_mc;
  logic        is_valid_from_mc;
  logic [7:0]  byte_from_mc;

  int total;
  int passed;

  icache_responder dut (
    .clk                  (clk),
    .rst                  (rst),
    .is_exception_from_rob(is_exception_from_rob),
    .is_empty_from_iq     (is_empty_from_iq),
    .pc_from_iq           (pc_from_iq),
    .is_hit_to_iq         (is_hit_to_iq),
    .instr_to_iq          (instr_to_iq),
    .is_request_to_mc     (is_request_to_mc),
    .addr_to_mc           (addr_to_mc),
    .is_valid_from_mc     (is_valid_from_mc),
    .byte_from_mc         (byte_from_mc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          miss;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Memory image: first word is "addi a0,x0,0"; elsewhere byte = low address byte ^ 0x5A.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0:   return 8'h13;
      32'h1:   return 8'h05;
      32'h2:   return 8'h00;
      32'h3:   return 8'h00;
      default: return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Called at a negedge with the cache idle; the request is held through the answer cycle.
  task automatic do_fetch(input string nm, input logic [31:0] pc, input bit miss, input logic [31:0] exp);
    is_empty_from_iq = 1'b0;
    pc_from_iq       = pc;
    @(negedge clk);
    if (!miss) begin
      check({nm, " hit"},   32'(is_hit_to_iq), 32'd1);
      check({nm, " instr"}, instr_to_iq, exp);
      check({nm, " no mc"}, 32'(is_request_to_mc), 32'd0);
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (n == 2) begin
          is_valid_from_mc = 1'b0;
          @(negedge clk);
        end
        check({nm, " req"},  32'(is_request_to_mc), 32'd1);
        check({nm, " addr"}, addr_to_mc, pc + 32'(n));
        check({nm, " early hit"}, 32'(is_hit_to_iq), 32'd0);
        is_valid_from_mc = 1'b1;
        byte_from_mc     = mem_byte(pc + 32'(n));
        @(negedge clk);
      end
      is_valid_from_mc = 1'b0;
      check({nm, " req drop"}, 32'(is_request_to_mc), 32'd0);
      check({nm, " hit"},      32'(is_hit_to_iq), 32'd1);
      check({nm, " instr"},    instr_to_iq, exp);
    end
    @(negedge clk);
    check({nm, " single pulse"}, 32'(is_hit_to_iq), 32'd0);
    check({nm, " idle mc"},      32'(is_request_to_mc), 32'd0);
    is_empty_from_iq = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    total = 0;
    passed = 0;
    vecs[0] = '{pc: 32'h0000_0000, miss: 1'b1, instr: 32'h0000_0513};  // cold miss
    vecs[1] = '{pc: 32'h0000_0000, miss: 1'b0, instr: 32'h0000_0513};  // warm hit
    vecs[2] = '{pc: 32'h0000_0040, miss: 1'b1, instr: 32'h1918_1B1A};  // conflict on index 0
    vecs[3] = '{pc: 32'h0000_0040, miss: 1'b0, instr: 32'h1918_1B1A};
    vecs[4] = '{pc: 32'h0000_0000, miss: 1'b1, instr: 32'h0000_0513};  // evicted, misses again
    vecs[5] = '{pc: 32'hFFFF_FFFC, miss: 1'b1, instr: 32'hA5A4_A7A6};  // top of address space
    vecs[6] = '{pc: 32'hFFFF_FFFC, miss: 1'b0, instr: 32'hA5A4_A7A6};
    vecs[7] = '{pc: 32'h0000_0000, miss: 1'b0, instr: 32'h0000_0513};

    rst = 1'b0;
    is_exception_from_rob = 1'b0;
    is_empty_from_iq = 1'b1;
    pc_from_iq = 32'h0;
    is_valid_from_mc = 1'b0;
    byte_from_mc = 8'h0;
    #12;
    check("reset hit",   32'(is_hit_to_iq), 32'd0);
    check("reset instr", instr_to_iq, 32'd0);
    check("reset req",   32'(is_request_to_mc), 32'd0);
    check("reset addr",  addr_to_mc, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].miss, vecs[i].instr);
    end

    // Flush after two bytes; the request held during the exception cycle is ignored.
    is_empty_from_iq = 1'b0;
    pc_from_iq = 32'h8;
    @(negedge clk);
    check("flush start req", 32'(is_request_to_mc), 32'd1);
    for (int n = 0; n < 2; n++) begin
      is_valid_from_mc = 1'b1;
      byte_from_mc = mem_byte(32'h8 + 32'(n));
      @(negedge clk);
    end
    is_valid_from_mc = 1'b0;
    is_exception_from_rob = 1'b1;
    @(negedge clk);
    check("flush req", 32'(is_request_to_mc), 32'd0);
    check("flush hit", 32'(is_hit_to_iq), 32'd0);
    is_exception_from_rob = 1'b0;
    is_empty_from_iq = 1'b1;
    is_valid_from_mc = 1'b1;
    byte_from_mc = 8'hEE;
    @(negedge clk);
    is_valid_from_mc = 1'b0;
    check("stale byte req", 32'(is_request_to_mc), 32'd0);
    check("stale byte hit", 32'(is_hit_to_iq), 32'd0);

    // Fourth byte coincident with the exception: no line write, no pulse.
    is_empty_from_iq = 1'b0;
    @(negedge clk);
    check("coinc start req", 32'(is_request_to_mc), 32'd1);
    check("coinc addr", addr_to_mc, 32'h8);
    for (int n = 0; n < 3; n++) begin
      is_valid_from_mc = 1'b1;
      byte_from_mc = mem_byte(32'h8 + 32'(n));
      @(negedge clk);
    end
    byte_from_mc = mem_byte(32'hB);
    is_exception_from_rob = 1'b1;
    @(negedge clk);
    is_valid_from_mc = 1'b0;
    is_exception_from_rob = 1'b0;
    is_empty_from_iq = 1'b1;
    check("coinc hit", 32'(is_hit_to_iq), 32'd0);
    check("coinc req", 32'(is_request_to_mc), 32'd0);
    @(negedge clk);
    check("coinc late hit", 32'(is_hit_to_iq), 32'd0);

    do_fetch("refetch8", 32'h8, 1'b1, 32'h5150_5352);
    do_fetch("hit8",     32'h8, 1'b0, 32'h5150_5352);

    // Asynchronous reset in the middle of a fill.
    is_empty_from_iq = 1'b0;
    pc_from_iq = 32'h20;
    @(negedge clk);
    check("rst fill req", 32'(is_request_to_mc), 32'd1);
    is_valid_from_mc = 1'b1;
    byte_from_mc = mem_byte(32'h20);
    @(negedge clk);
    is_valid_from_mc = 1'b0;
    is_empty_from_iq = 1'b1;
    check("rst fill addr", addr_to_mc, 32'h21);
    #2 rst = 1'b0;
    #1;
    check("async rst req",   32'(is_request_to_mc), 32'd0);
    check("async rst addr",  addr_to_mc, 32'd0);
    check("async rst hit",   32'(is_hit_to_iq), 32'd0);
    check("async rst instr", instr_to_iq, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_fetch("post rst pc0", 32'h0, 1'b1, 32'h0000_0513);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
